// File: rtl/maxpool_axil_responder.sv
// AXI4-Lite responder backed by a 16x32 register file with per-byte write strobes.
// Optional macro MAXPOOL_AXIL_SLVERR_EN answers SLVERR for words above LAST_WORD.
module maxpool_axil_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NUM_WORDS = 1 << IDX_W;
    localparam int STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshake rule on every channel: a beat transfers on the rising edge where
    // VALID && READY are both high; the source holds VALID and payload until then.

    logic                          ready_en;
    logic                          aw_held;
    logic                          w_held;
    logic [IDX_W-1:0]              aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]             wstrb_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;
    logic                          rvalid_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          wr_fire;
    logic [IDX_W-1:0]              wr_idx;
    logic [IDX_W-1:0]              rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic                          wr_err;
    logic                          rd_err;
    logic                          unused_bits;

    // ready_en keeps all READYs low until the first edge after reset release
    assign S_AXI_AWREADY = ready_en && !aw_held && !bvalid_q;
    assign S_AXI_WREADY  = ready_en && !w_held && !bvalid_q;
    assign S_AXI_ARREADY = ready_en && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid_q;

`ifdef MAXPOOL_AXIL_SLVERR_EN
    localparam int LAST_WORD = (NUM_WORDS * 3) / 4 - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_WORD);
    assign wr_err = (wr_idx > LAST_IDX);
    assign rd_err = (rd_idx > LAST_IDX);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            // Latches stay set while BVALID is up so no second write can sneak in
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                rdata_q  <= rd_err ? '0 : mem[rd_idx];
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Read above samples mem before this edge's write lands: same-word reads see old data
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_fire && !wr_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule
